pwm_ramp_ctrl: RTL
==================

Name: pwm_ramp_ctrl

Overview:
Sequencer that drives the `number` (duty) input of the PWM generator for one drive motor of the vacuum cleaner.
- Accepts speed/direction commands from the navigation logic over a valid/ready handshake.
- Slews duty toward the target in fixed steps (soft start/stop).
- On a direction reversal, ramps to zero, holds a dead-time with the bridge disabled, flips direction, then ramps back up.
- Provides an emergency stop that overrides everything.

Parameters:
- LENGHT, 10, duty width; must equal the PWM generator's LENGHT.
- STEP, 8, duty increment/decrement per ramp tick (1..2^LENGHT-1).
- RAMP_DIV, 1000, clk cycles per ramp tick (≥1).
- DEAD_CYCLES, 500, clk cycles the bridge is held disabled during reversal (≥1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready.
- cmd_duty  in  LENGHT  target duty.
- cmd_dir  in  1  target direction (0 forward, 1 reverse).
- estop  in  1  emergency stop, level-sensitive.
- duty  out  LENGHT  to PWM `number`.
- dir  out  1  to H-bridge direction pin.
- drive_en  out  1  H-bridge enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when duty reaches target in the commanded direction.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, duty=0, dir=0, drive_en=0, done=0, target=0, tgt_dir=0, prescaler=0, dead counter=0. Reset mid-ramp or mid-DEAD aborts immediately to these values.
- States: IDLE, RAMP, DEAD.
- cmd_ready = (state != DEAD) & ~estop. It is combinational from registered state.
- On accept: latch target=cmd_duty, tgt_dir=cmd_dir; reset prescaler to 0; next state RAMP. A new command during RAMP replaces the target (retarget) without glitching duty.
- drive_en is set to 1 on accept.
- Prescaler counts 0..RAMP_DIV-1 in RAMP; a tick fires when it equals RAMP_DIV-1. The first step occurs RAMP_DIV cycles after accept.
- RAMP, per tick, when tgt_dir == dir:
  - If |target - duty| ≤ STEP: duty = target, pulse done, go to IDLE.
  - Otherwise duty moves STEP toward target.
- RAMP, per tick, when tgt_dir != dir: ramp toward 0 with the same clamping rule.
  - On reaching 0: go to DEAD, drive_en=0, load the dead counter.
  - If duty is already 0 at accept with tgt_dir != dir: go to DEAD on the next cycle without waiting for a tick.
- Step arithmetic: compute in LENGHT+1 bits. Never wrap — no overflow above 2^LENGHT-1 and no underflow below 0.
- DEAD: drive_en=0, duty=0 for exactly DEAD_CYCLES cycles. Then dir=tgt_dir, drive_en=1, prescaler=0, next state RAMP (or IDLE with done if target=0). cmd_valid is ignored.
- A command with target==duty and tgt_dir==dir completes on the next cycle: done pulse, IDLE, no tick wait.
- Entering IDLE with duty=0 clears drive_en.
- estop=1 has priority over commands and states; effective next cycle:
  - duty=0, drive_en=0, state=IDLE, target=0.
  - dir holds its value; no done pulse.
  - Commands are refused while estop is high.
- Simultaneous cmd accept and tick in RAMP: the new target applies and the prescaler restarts; that tick's step is discarded.

Decomposition:
- Shared package (e.g. `motor_pkg`): state enum {IDLE, RAMP, DEAD} and DIR_FWD/DIR_REV constants. This package is reused by the second motor instance and the navigation FSM.
- One natural sub-module: `tick_gen` (RAMP_DIV prescaler with sync clear, tick output).
- The dead counter stays inline.

Test Plan (LENGHT=10, STEP=4, RAMP_DIV=2, DEAD_CYCLES=3):
1. Reset, then cmd duty=10 dir=0 → duty 0,4,8,10 at successive ticks every 2 cycles; done pulses once; busy falls; drive_en=1 throughout; dir=0.
2. From duty=10 dir=0, cmd duty=6 dir=1 → duty 6,2,0; drive_en=0 for exactly 3 cycles; dir goes 1; duty 4,6; done once.
3. Mid-ramp (duty=8, target 40), assert estop → next cycle duty=0, drive_en=0, busy=0, cmd_ready=0. Deassert, cmd duty=4 → normal ramp.
4. Retarget: ramping up toward 40 at duty=12, cmd duty=2 dir=0 → duty 8,4,2, done. Steps never overshoot and never go negative.
5. Boundary: cmd duty=1023 from 1020 → single clamp to 1023, no wrap. cmd duty=0 from 2 → 0 (no underflow), drive_en clears.
6. rst_n low during DEAD → all outputs at reset values next cycle. Commands during DEAD are refused (cmd_ready=0, no latch).

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : pwm_ramp_ctrl_pkg
// Purpose : motor sequencer state encoding and direction constants
// Rev     : 1.0
// ----------------------------------------------------------------------------
package pwm_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_ctrl_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pwm_ramp_ctrl_tick_gen
// Purpose : RAMP_DIV prescaler with synchronous clear, one-cycle tick output
// Rev     : 1.0
// ----------------------------------------------------------------------------
module pwm_ramp_ctrl_tick_gen
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int c_cnt_w = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int c_last_i = RAMP_DIV - 1;
  localparam logic [c_cnt_w-1:0] c_last = c_last_i[c_cnt_w-1:0];

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_last);
  assign tick      = en & w_at_last;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pwm_ramp_ctrl
// Purpose : duty slew, reversal dead-time and e-stop sequencer for one motor
// Rev     : 1.0
// ----------------------------------------------------------------------------
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int LENGHT      = 10,
  parameter int STEP        = 8,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LENGHT-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              estop,
  output logic [LENGHT-1:0] duty,
  output logic              dir,
  output logic              drive_en,
  output logic              busy,
  output logic              done
);

  localparam logic [LENGHT:0] c_step = STEP[LENGHT:0];
  localparam int c_dead_w = $clog2(DEAD_CYCLES + 1);
  localparam int c_dead_m1 = DEAD_CYCLES - 1;
  localparam logic [c_dead_w-1:0] c_dead_load = c_dead_m1[c_dead_w-1:0];

  state_t              r_state;
  logic [LENGHT-1:0]   r_target;
  logic                r_tgt_dir;
  logic [c_dead_w-1:0] r_dead_cnt;

  logic              w_fire;
  logic              w_tick;
  logic [LENGHT:0]   w_duty_ext;
  logic [LENGHT:0]   w_tgt_ext;
  logic [LENGHT:0]   w_diff;
  logic [LENGHT:0]   w_up;
  logic [LENGHT:0]   w_dn;
  logic [LENGHT-1:0] w_up_sat;
  logic [LENGHT-1:0] w_dn_sat;

  assign cmd_ready = (r_state != DEAD) & ~estop;
  assign busy      = (r_state != IDLE);
  assign w_fire    = cmd_valid & cmd_ready;

  // Step math carries one extra bit so the carry/borrow can saturate
  assign w_duty_ext = {1'b0, duty};
  assign w_tgt_ext  = {1'b0, r_target};
  assign w_diff     = (w_tgt_ext >= w_duty_ext) ? (w_tgt_ext - w_duty_ext)
                                                : (w_duty_ext - w_tgt_ext);
  assign w_up       = w_duty_ext + c_step;
  assign w_dn       = w_duty_ext - c_step;
  assign w_up_sat   = w_up[LENGHT] ? '1 : w_up[LENGHT-1:0];
  assign w_dn_sat   = w_dn[LENGHT] ? '0 : w_dn[LENGHT-1:0];

  pwm_ramp_ctrl_tick_gen #(
    .RAMP_DIV(RAMP_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_fire | (r_state != RAMP)),
    .en   (r_state == RAMP),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_tgt_dir  <= DIR_FWD;
      r_dead_cnt <= '0;
      duty       <= '0;
      dir        <= DIR_FWD;
      drive_en   <= 1'b0;
      done       <= 1'b0;
    end else if (estop) begin
      r_state  <= IDLE;
      r_target <= '0;
      duty     <= '0;
      drive_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, RAMP: begin
          if (w_fire) begin
            // A command landing on a tick wins; that tick's step is dropped
            r_target  <= cmd_duty;
            r_tgt_dir <= cmd_dir;
            drive_en  <= 1'b1;
            r_state   <= RAMP;
          end else if (r_state == RAMP) begin
            if (r_tgt_dir != dir) begin
              if (duty == '0) begin
                r_state    <= DEAD;
                drive_en   <= 1'b0;
                r_dead_cnt <= c_dead_load;
              end else if (w_tick) begin
                if (w_duty_ext <= c_step) begin
                  duty       <= '0;
                  r_state    <= DEAD;
                  drive_en   <= 1'b0;
                  r_dead_cnt <= c_dead_load;
                end else begin
                  duty <= w_dn_sat;
                end
              end
            end else if ((duty == r_target) || (w_tick && (w_diff <= c_step))) begin
              duty     <= r_target;
              done     <= 1'b1;
              r_state  <= IDLE;
              drive_en <= (r_target != '0);
            end else if (w_tick) begin
              duty <= (r_target > duty) ? w_up_sat : w_dn_sat;
            end
          end
        end
        DEAD: begin
          duty     <= '0;
          drive_en <= 1'b0;
          if (r_dead_cnt == '0) begin
            dir <= r_tgt_dir;
            if (r_target == '0) begin
              r_state <= IDLE;
              done    <= 1'b1;
            end else begin
              r_state  <= RAMP;
              drive_en <= 1'b1;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
